// File: rtl/lsu_mem_ctrl.sv
// ----------------------------------------------------------------------------
// lsu_mem_ctrl : load/store controller for a word-wide data memory with
// byte/half support via lane extraction and read-modify-write.
// Optional macro LSU_MISALIGN_CHECK_EN: report misalignment instead of force-aligning.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lsu_mem_ctrl #(
  parameter int MEM_BYTES = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam logic [ADDR_W-1:0] MAX_WADDR = ADDR_W'(MEM_BYTES - 4);
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t state, state_n;

  logic [1:0]        op_size;
  logic              op_unsigned;
  logic [1:0]        op_lane;
  logic [15:0]       op_wdata;

  logic              ready_n, rsp_valid_n, rsp_err_n, mem_we_n, mem_re_n;
  logic [31:0]       rsp_rdata_n, mem_wdata_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [ADDR_W-1:0] eff_addr, word_addr;
  logic              misalign, req_err, capture;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_BYTE: load_ext = {{24{~uns & b[7]}}, b};
      SZ_HALF: load_ext = {{16{~uns & h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] lane,
                                        input logic [1:0] sz, input logic [15:0] d);
    logic [31:0] m;
    m = w;
    if (sz == SZ_BYTE) m[{lane, 3'b000} +: 8] = d[7:0];
    else if (lane[1]) m[31:16] = d;
    else m[15:0] = d;
    return m;
  endfunction

  // Request decode: effective address and error classification at accept time.
  always_comb begin
`ifdef LSU_MISALIGN_CHECK_EN
    misalign = ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
               ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
    eff_addr = req_addr_i;
`else
    misalign = 1'b0;
    eff_addr = req_addr_i;
    if (req_size_i == SZ_HALF) eff_addr[0] = 1'b0;
    else if (req_size_i == SZ_WORD) eff_addr[1:0] = 2'b00;
`endif
    word_addr = {eff_addr[ADDR_W-1:2], 2'b00};
    req_err   = misalign || (req_size_i == SZ_BAD) || (word_addr > MAX_WADDR);
  end

  always_comb begin
    state_n     = state;
    capture     = 1'b0;
    mem_re_n    = 1'b0;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr_o;
    mem_wdata_n = mem_wdata_o;
    rsp_valid_n = 1'b0;
    rsp_err_n   = 1'b0;
    rsp_rdata_n = 32'd0;
    case (state)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          capture = 1'b1;
          if (req_err) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
          end else if (!req_we_i) begin
            state_n    = LOAD;
            mem_re_n   = 1'b1;
            mem_addr_n = word_addr;
          end else if (req_size_i == SZ_WORD) begin
            state_n     = STORE;
            mem_we_n    = 1'b1;
            mem_addr_n  = word_addr;
            mem_wdata_n = req_wdata_i;
          end else begin
            state_n    = RMW_RD;
            mem_re_n   = 1'b1;
            mem_addr_n = word_addr;
          end
        end
      end
      LOAD: begin
        state_n     = RESP;
        rsp_valid_n = 1'b1;
        rsp_rdata_n = load_ext(mem_rdata_i, op_lane, op_size, op_unsigned);
      end
      STORE: begin
        state_n     = RESP;
        rsp_valid_n = 1'b1;
      end
      RMW_RD: begin
        // The merged word is formed here so the write cycle drives a stable register.
        state_n     = RMW_WR;
        mem_we_n    = 1'b1;
        mem_wdata_n = merge(mem_rdata_i, op_lane, op_size, op_wdata);
      end
      RMW_WR: begin
        state_n     = RESP;
        rsp_valid_n = 1'b1;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= 32'd0;
      mem_we_o    <= 1'b0;
      mem_re_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= 32'd0;
      op_size     <= 2'b00;
      op_unsigned <= 1'b0;
      op_lane     <= 2'b00;
      op_wdata    <= 16'd0;
    end else begin
      state       <= state_n;
      req_ready_o <= ready_n;
      rsp_valid_o <= rsp_valid_n;
      rsp_err_o   <= rsp_err_n;
      rsp_rdata_o <= rsp_rdata_n;
      mem_we_o    <= mem_we_n;
      mem_re_o    <= mem_re_n;
      mem_addr_o  <= mem_addr_n;
      mem_wdata_o <= mem_wdata_n;
      if (capture) begin
        op_size     <= req_size_i;
        op_unsigned <= req_unsigned_i;
        op_lane     <= eff_addr[1:0];
        op_wdata    <= req_wdata_i[15:0];
      end
    end
  end

  assign stall_o = ~req_ready_o;

endmodule

`default_nettype wire
